// File: rtl/fifo_pkg.sv
// Shared types and constants for the FWFT FIFO family.
// Default sizing matches the projected-triangle queue between transform and rasteriser.
package fifo_pkg;

    typedef logic [2:0][1:0][9:0] tri2d_t;

    localparam int TRI_W     = $bits(tri2d_t);
    localparam int DEPTH_DEF = 128;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_LOADING,
        HEAD_VALID
    } head_state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Kept minimal so synthesis maps it onto block RAM.
module fifo_sdp_ram #(
    parameter int Wdata = 60,
    parameter int Depth = 128,
    parameter int Waddr = $clog2(Depth)
) (
    input  logic             Clk,
    input  logic             we,
    input  logic [Waddr-1:0] waddr,
    input  logic [Wdata-1:0] wdata,
    input  logic             re,
    input  logic [Waddr-1:0] raddr,
    output logic [Wdata-1:0] rdata
);

    logic [Wdata-1:0] mem [Depth];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/prim_fifo_fwft.sv
// First-word-fall-through FIFO: block RAM plus the RAM read register as a prefetch
// stage and data_out as the head register, both counted in count.
//
//  state         | meaning
//  HEAD_EMPTY    | no head, nothing waiting in the RAM read register
//  HEAD_LOADING  | no head yet, RAM read register holds the next head
//  HEAD_VALID    | data_out holds the head (RAM read register may hold the next one)
module prim_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int Wdata = TRI_W,
    parameter int Depth = DEPTH_DEF,
    parameter int Waddr = $clog2(Depth),
    parameter int AF_TH = Depth - 4,
    parameter int AE_TH = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       flush,
    input  logic                       w_en,
    input  logic [Wdata-1:0]           data_in,
    input  logic                       r_en,
    output logic [Wdata-1:0]           data_out,
    output logic                       is_empty,
    output logic                       is_full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int Wcnt = cnt_w(Depth);

    head_state_e      state, state_nxt;
    logic [Waddr-1:0] wptr, rptr;
    logic [Wcnt-1:0]  count_nxt, ram_cnt;
    logic             q_valid, q_valid_nxt;
    logic             out_valid, out_valid_nxt;
    logic             push, pop, rd_en, load_out;
    logic [Wdata-1:0] ram_q;

    function automatic logic [Waddr-1:0] ptr_inc(input logic [Waddr-1:0] p);
        return (p == Waddr'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    fifo_sdp_ram #(
        .Wdata (Wdata),
        .Depth (Depth),
        .Waddr (Waddr)
    ) u_ram (
        .Clk   (Clk),
        .we    (push),
        .waddr (wptr),
        .wdata (data_in),
        .re    (rd_en),
        .raddr (rptr),
        .rdata (ram_q)
    );

    assign out_valid = (state == HEAD_VALID);
    assign is_empty  = !out_valid;

    // Entries written to RAM but not yet read out into the prefetch stage.
    assign ram_cnt = count - Wcnt'(out_valid) - Wcnt'(q_valid);

    always_comb begin
        push          = w_en && !is_full && !flush;
        pop           = r_en && out_valid && !flush;
        load_out      = !flush && q_valid && (!out_valid || pop);
        rd_en         = !flush && (ram_cnt != '0) && (!q_valid || load_out);
        out_valid_nxt = load_out || (out_valid && !pop);
        q_valid_nxt   = rd_en || (q_valid && !load_out);
        state_nxt     = state;
        if (flush) begin
            q_valid_nxt = 1'b0;
            state_nxt   = HEAD_EMPTY;
        end else if (out_valid_nxt) begin
            state_nxt = HEAD_VALID;
        end else if (q_valid_nxt) begin
            state_nxt = HEAD_LOADING;
        end else begin
            state_nxt = HEAD_EMPTY;
        end
    end

    always_comb begin
        count_nxt = count;
        if (flush)              count_nxt = '0;
        else if (push && !pop)  count_nxt = count + 1'b1;
        else if (pop && !push)  count_nxt = count - 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= HEAD_EMPTY;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            q_valid      <= 1'b0;
            data_out     <= '0;
            is_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            q_valid      <= q_valid_nxt;
            is_full      <= (count_nxt == Wcnt'(Depth));
            almost_full  <= (int'(count_nxt) >= AF_TH);
            almost_empty <= (int'(count_nxt) <= AE_TH);
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)  wptr <= ptr_inc(wptr);
                if (rd_en) rptr <= ptr_inc(rptr);
                if (w_en && is_full)  overflow  <= 1'b1;
                if (r_en && is_empty) underflow <= 1'b1;
            end
            if (load_out) data_out <= ram_q;
        end
    end

endmodule
